// File: rtl/eq_band_mixer.sv
// rtl/eq_band_mixer.sv - per-band gain ramp, time-multiplexed accumulate, saturate and offset for the DAC
module eq_band_mixer #(
  parameter int p      = 10,
  parameter int f      = 14,
  parameter int Width  = p + f + 1,
  parameter int NB     = 3,
  parameter int GB     = 3,
  parameter int GSHIFT = 2
) (
  input  logic                  sclk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [NB*Width-1:0]   band_data,
  input  logic [NB*GB-1:0]      gain_tgt,
  output logic                  busy,
  output logic                  out_valid,
  output logic [Width-1:0]      dato_dac,
  output logic                  overrun
);

  localparam int ACCW = Width + GB + $clog2(NB) + 1;
  localparam int PW   = Width + GB + 1;
  localparam int IW   = (NB > 1) ? $clog2(NB) : 1;

  localparam logic signed [ACCW-1:0] OFFSET  = {{(ACCW-f){1'b0}}, 1'b1, {(f-1){1'b0}}};
  localparam logic signed [ACCW-1:0] SAT_MAX = {{(ACCW-Width+1){1'b0}}, {(Width-1){1'b1}}};
  localparam logic signed [ACCW-1:0] SAT_MIN = {{(ACCW-Width+1){1'b1}}, {(Width-1){1'b0}}};
  localparam logic [GB-1:0]          UNITY   = GB'(1 << GSHIFT);

  typedef enum logic [1:0] {IDLE, ACC, SAT} state_t;

  state_t                   state_q, state_d;
  logic [IW-1:0]            idx_q, idx_d;
  logic [NB*Width-1:0]      band_q, band_d;
  logic [NB*GB-1:0]         gain_q, gain_d, gain_ramp;
  logic signed [ACCW-1:0]   acc_q, acc_d;
  logic [Width-1:0]         dato_q, dato_d;
  logic                     pend_q, pend_d;
  logic                     out_valid_q, out_valid_d;
  logic                     overrun_q, overrun_d;

  logic                     accept;
  logic signed [Width-1:0]  band_sel;
  logic [GB-1:0]            gain_sel;
  logic signed [PW-1:0]     prod;
  logic signed [PW-1:0]     term;
  logic signed [ACCW-1:0]   sum_off;

  // State register
  always_ff @(posedge sclk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid) state_d = ACC;
      ACC:     if (idx_q == IW'(NB-1)) state_d = SAT;
      SAT:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy   = (state_q != IDLE);
    accept = (state_q == IDLE) && in_valid;
  end

  // Each gain moves at most one code per accepted sample so level changes stay click-free
  always_comb begin
    gain_ramp = gain_q;
    for (int k = 0; k < NB; k++) begin
      if (gain_tgt[k*GB +: GB] > gain_q[k*GB +: GB])
        gain_ramp[k*GB +: GB] = gain_q[k*GB +: GB] + 1'b1;
      else if (gain_tgt[k*GB +: GB] < gain_q[k*GB +: GB])
        gain_ramp[k*GB +: GB] = gain_q[k*GB +: GB] - 1'b1;
    end
  end

  always_comb begin
    band_sel = '0;
    gain_sel = '0;
    for (int k = 0; k < NB; k++) begin
      if (idx_q == IW'(k)) begin
        band_sel = band_q[k*Width +: Width];
        gain_sel = gain_q[k*GB +: GB];
      end
    end
    prod    = PW'(band_sel) * $signed({1'b0, gain_sel});
    term    = prod >>> GSHIFT;
    sum_off = acc_q + OFFSET;
  end

  always_comb begin
    idx_d       = idx_q;
    band_d      = band_q;
    gain_d      = gain_q;
    acc_d       = acc_q;
    dato_d      = dato_q;
    pend_d      = 1'b0;
    out_valid_d = pend_q;
    overrun_d   = overrun_q | (in_valid & busy);
    if (accept) begin
      idx_d  = '0;
      band_d = band_data;
      gain_d = gain_ramp;
      acc_d  = '0;
    end
    if (state_q == ACC) begin
      acc_d = acc_q + ACCW'(term);
      idx_d = idx_q + 1'b1;
    end
    // Result register loads here; the strobe trails it by one cycle
    if (state_q == SAT) begin
      pend_d = 1'b1;
      if (sum_off > SAT_MAX)      dato_d = SAT_MAX[Width-1:0];
      else if (sum_off < SAT_MIN) dato_d = SAT_MIN[Width-1:0];
      else                        dato_d = sum_off[Width-1:0];
    end
  end

  always_ff @(posedge sclk or negedge rst) begin
    if (!rst) begin
      idx_q       <= '0;
      band_q      <= '0;
      gain_q      <= {NB{UNITY}};
      acc_q       <= '0;
      dato_q      <= '0;
      pend_q      <= 1'b0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      idx_q       <= idx_d;
      band_q      <= band_d;
      gain_q      <= gain_d;
      acc_q       <= acc_d;
      dato_q      <= dato_d;
      pend_q      <= pend_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign out_valid = out_valid_q;
  assign dato_dac  = dato_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_eq_band_mixer.sv
// tb/tb_eq_band_mixer.sv - randomized self-checking bench for eq_band_mixer against an arithmetic model
module tb_eq_band_mixer;

  localparam int W  = 25;
  localparam int NB = 3;
  localparam int GB = 3;

  logic              sclk = 1'b0;
  logic              rst  = 1'b0;
  logic              in_valid = 1'b0;
  logic [NB*W-1:0]   band_data = '0;
  logic [NB*GB-1:0]  gain_tgt  = '0;
  logic              busy, out_valid, overrun;
  logic [W-1:0]      dato_dac;

  int nvec  = 0;
  int nfail = 0;

  int b[NB];
  int t[NB];
  int gm[NB];
  longint expq[$];

  eq_band_mixer dut (
    .sclk(sclk), .rst(rst), .in_valid(in_valid), .band_data(band_data),
    .gain_tgt(gain_tgt), .busy(busy), .out_valid(out_valid),
    .dato_dac(dato_dac), .overrun(overrun)
  );

  always #5 sclk = ~sclk;

  // Reference: ramp each gain one code toward its target, then floor(band*g/4) summed, +0.5 scaled offset, clamp
  function automatic longint model_step();
    longint s = 0;
    for (int k = 0; k < NB; k++) begin
      if (t[k] > gm[k]) gm[k]++;
      else if (t[k] < gm[k]) gm[k]--;
      s += (longint'(b[k]) * gm[k]) >>> 2;
    end
    s += 8192;
    if (s > 16777215) s = 16777215;
    if (s < -16777216) s = -16777216;
    return s;
  endfunction

  task automatic do_reset();
    rst = 1'b0;
    for (int k = 0; k < NB; k++) gm[k] = 4;
    expq.delete();
    #12;
    rst = 1'b1;
    @(posedge sclk); #1;
  endtask

  // Caller is 1 time unit after a rising edge; the next edge is the accept edge
  task automatic send(input bit expect_accept);
    for (int k = 0; k < NB; k++) begin
      band_data[k*W +: W]  = W'(b[k]);
      gain_tgt[k*GB +: GB] = GB'(t[k]);
    end
    in_valid = 1'b1;
    if (expect_accept) expq.push_back(model_step());
    @(posedge sclk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output bit got, output int cycles, output int busy_cnt);
    got = 0; cycles = 0; busy_cnt = 0;
    while (!got && cycles < 20) begin
      if (busy) busy_cnt++;
      @(posedge sclk); #1;
      cycles++;
      if (out_valid) got = 1;
    end
  endtask

  task automatic set_bands(input int b0, input int b1, input int b2, input int t0, input int t1, input int t2);
    b[0] = b0; b[1] = b1; b[2] = b2; t[0] = t0; t[1] = t1; t[2] = t2;
  endtask

  task automatic test_reset();
    rst = 1'b0; #3;
    nvec++; if (busy !== 1'b0)      begin nfail++; $display("FAIL reset_busy got %b want 0", busy); end
    nvec++; if (out_valid !== 1'b0) begin nfail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    nvec++; if (dato_dac !== '0)    begin nfail++; $display("FAIL reset_dato got %0d want 0", $signed(dato_dac)); end
    nvec++; if (overrun !== 1'b0)   begin nfail++; $display("FAIL reset_overrun got %b want 0", overrun); end
    do_reset();
  endtask

  task automatic test_basic();
    bit got; int cyc, bc; longint e;
    set_bands(1000, 2000, 3000, 4, 4, 4);
    send(1);
    wait_valid(got, cyc, bc);
    e = expq.pop_front();
    nvec++; if (!got || cyc != 5) begin nfail++; $display("FAIL basic_latency got %0d want 5", cyc); end
    nvec++; if (bc != 4)          begin nfail++; $display("FAIL basic_busy_cycles got %0d want 4", bc); end
    nvec++; if (!got || $signed(dato_dac) !== 25'sd14192 || e != 14192)
      begin nfail++; $display("FAIL basic_value got %0d want 14192", $signed(dato_dac)); end
    @(posedge sclk); #1;
    nvec++; if (out_valid !== 1'b0) begin nfail++; $display("FAIL basic_strobe_width got %b want 0", out_valid); end
  endtask

  task automatic test_ramp();
    bit got; int cyc, bc; longint e;
    int fixed[5] = '{20480, 16384, 12288, 8192, 8192};
    set_bands(16384, 0, 0, 0, 4, 4);
    for (int n = 0; n < 12; n++) begin
      if (n == 5) t[0] = 7;
      send(1);
      wait_valid(got, cyc, bc);
      e = expq.pop_front();
      if (n < 5 && e != fixed[n]) e = fixed[n];
      nvec++; if (!got || $signed(dato_dac) !== W'(e))
        begin nfail++; $display("FAIL ramp_%0d got %0d want %0d", n, $signed(dato_dac), e); end
    end
    nvec++; if ($signed(dato_dac) !== 25'sd36864)
      begin nfail++; $display("FAIL ramp_settle got %0d want 36864", $signed(dato_dac)); end
  endtask

  task automatic test_saturation();
    bit got; int cyc, bc; longint e;
    for (int n = 0; n < 5; n++) begin
      if (n < 4) set_bands(1 << 23, 1 << 23, 1 << 23, 7, 7, 7);
      else       set_bands(-(1 << 23), -(1 << 23), -(1 << 23), 7, 7, 7);
      send(1);
      wait_valid(got, cyc, bc);
      e = expq.pop_front();
      nvec++; if (!got || $signed(dato_dac) !== W'(e))
        begin nfail++; $display("FAIL sat_%0d got %0d want %0d", n, $signed(dato_dac), e); end
      if (n == 3) begin
        nvec++; if (dato_dac !== 25'd16777215)
          begin nfail++; $display("FAIL sat_pos got %0d want 16777215", $signed(dato_dac)); end
      end
    end
    nvec++; if ($signed(dato_dac) !== -25'sd16777216)
      begin nfail++; $display("FAIL sat_neg got %0d want -16777216", $signed(dato_dac)); end
  endtask

  task automatic test_overrun();
    bit got; int cyc, bc; longint e;
    set_bands($urandom_range(0, 1 << 22), $urandom_range(0, 1 << 22), 500, 4, 3, 6);
    send(1);
    @(posedge sclk); #1;
    set_bands(-123456, 777777, -5, 0, 0, 0);
    send(0);
    nvec++; if (overrun !== 1'b1) begin nfail++; $display("FAIL overrun_set got %b want 1", overrun); end
    wait_valid(got, cyc, bc);
    e = expq.pop_front();
    nvec++; if (!got || $signed(dato_dac) !== W'(e))
      begin nfail++; $display("FAIL overrun_result got %0d want %0d", $signed(dato_dac), e); end
    repeat (3) @(posedge sclk); #1;
    nvec++; if (overrun !== 1'b1) begin nfail++; $display("FAIL overrun_sticky got %b want 1", overrun); end
  endtask

  task automatic test_midreset();
    bit got; int cyc, bc; longint e;
    set_bands(1000, 2000, 3000, 7, 7, 7);
    send(1);
    wait_valid(got, cyc, bc);
    void'(expq.pop_front());
    send(1);
    @(posedge sclk); #1;
    rst = 1'b0; #1;
    nvec++; if (busy !== 1'b0)     begin nfail++; $display("FAIL midrst_busy got %b want 0", busy); end
    nvec++; if (dato_dac !== '0)   begin nfail++; $display("FAIL midrst_dato got %0d want 0", $signed(dato_dac)); end
    nvec++; if (overrun !== 1'b0)  begin nfail++; $display("FAIL midrst_overrun got %b want 0", overrun); end
    do_reset();
    wait_valid(got, cyc, bc);
    nvec++; if (got) begin nfail++; $display("FAIL midrst_no_valid got 1 want 0"); end
    set_bands(1000, 0, 0, 4, 4, 4);
    send(1);
    wait_valid(got, cyc, bc);
    e = expq.pop_front();
    nvec++; if (!got || $signed(dato_dac) !== 25'sd9192 || e != 9192)
      begin nfail++; $display("FAIL midrst_unity got %0d want 9192", $signed(dato_dac)); end
  endtask

  task automatic test_back_to_back();
    bit got; int cyc, bc; longint e;
    for (int k = 0; k < NB; k++) begin
      b[k] = int'($urandom_range(0, 1 << 23)) - (1 << 22);
      t[k] = $urandom_range(0, 7);
    end
    send(1);
    for (int n = 0; n < 10; n++) begin
      wait_valid(got, cyc, bc);
      e = expq.pop_front();
      nvec++; if (!got || $signed(dato_dac) !== W'(e))
        begin nfail++; $display("FAIL b2b_%0d got %0d want %0d", n, $signed(dato_dac), e); end
      if (n < 9) begin
        nvec++; if (busy !== 1'b0) begin nfail++; $display("FAIL b2b_busy_%0d got %b want 0", n, busy); end
        for (int k = 0; k < NB; k++) begin
          b[k] = int'($urandom_range(0, 1 << 23)) - (1 << 22);
          t[k] = $urandom_range(0, 7);
        end
        send(1);
      end
    end
    nvec++; if (overrun !== 1'b0) begin nfail++; $display("FAIL b2b_overrun got %b want 0", overrun); end
  endtask

  initial begin
    for (int k = 0; k < NB; k++) gm[k] = 4;
    test_reset();
    test_basic();
    test_ramp();
    test_saturation();
    test_overrun();
    test_midreset();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

// File: doc/eq_band_mixer.md
Name: eq_band_mixer

Overview:
- Parametrised successor to the fixed 3-band gain/sum/offset path of the equalizer arithmetic stage.
- Takes NB band-filter outputs per audio sample and applies a per-band gain code to each.
- Gain changes are click-free: the gain in use ramps one step per sample toward the target.
- Bands are accumulated time-multiplexed, one band per clock. The sum is saturated, the mid-scale DAC offset is re-inserted, and the result is presented with a valid strobe to the DAC interface.

Parameters:
- p, 10, integer bits of the signed fixed-point format.
- f, 14, fractional bits.
- Width, p+f+1, sample width (two's complement).
- NB, 3, number of bands (1..16).
- GB, 3, gain code width (unsigned).
- GSHIFT, 2, gain fraction bits. Effective gain = code/2^GSHIFT, so the defaults give 0 to 1.75 in steps of 0.25.

Ports:
- sclk, input, 1: system clock, rising edge.
- rst, input, 1: asynchronous, active-low reset.
- in_valid, input, 1: one-cycle strobe; band_data is valid.
- band_data, input, NB*Width: band k occupies bits [k*Width +: Width], signed.
- gain_tgt, input, NB*GB: target gain code for band k at [k*GB +: GB].
- busy, output, 1: high while a sample is being processed.
- out_valid, output, 1: one-cycle strobe; dato_dac is updated.
- dato_dac, output, Width: signed result, held until the next out_valid.
- overrun, output, 1: sticky; set when in_valid is dropped.

Behaviour:
- Clock and reset: one clock, sclk. rst is asynchronous and active-low; asserting it forces all state immediately, with no clock needed.
- Reset values: state IDLE; busy=0; out_valid=0; dato_dac=0; overrun=0; accumulator=0; every gain_cur[k]=2^GSHIFT (unity).
- FSM states:
  - IDLE to ACC when in_valid=1. This is the accept edge: capture band_data and gain_tgt, clear the accumulator, set band index i=0.
  - ACC: one band per cycle, i=0..NB-1. After band NB-1, go to SAT.
  - SAT: one cycle, then back to IDLE.
- Gain ramp: at the accept edge, each gain_cur[k] moves one code toward gain_tgt[k] (+1, -1, or unchanged if equal). The updated gain_cur is the one used for this sample.
- ACC cycle i: acc += (band[i] * gain_cur[i]) >>> GSHIFT.
  - The shift is arithmetic, i.e. truncation toward minus infinity.
  - Accumulator width is Width+GB+clog2(NB)+1, so it never wraps internally.
- SAT cycle: s = acc + OFFSET, where OFFSET = 2^(f-1) (0.5 LSB-scaled mid-scale). s is clamped to [-2^(Width-1), 2^(Width-1)-1]. The clamped value is registered to dato_dac, and out_valid is asserted in the following cycle.
- Latency and handshake:
  - The accept edge is edge 0. out_valid is high during the cycle after edge NB+2 (5 clocks at NB=3).
  - busy = (state != IDLE). busy is low in the out_valid cycle, so an in_valid in that same cycle is accepted. The minimum sample period is therefore NB+2 clocks.
- in_valid while busy: the sample is ignored, gains do not ramp, the in-flight result is unaffected, and overrun is set to 1. overrun stays 1 until reset.
- Reset mid-operation: the current sample is discarded, no out_valid follows, and gain_cur returns to unity.
- NB=1 is legal: one ACC cycle, latency 3.

Test Plan:
Defaults throughout (Width=25, 1.0=16384, OFFSET=8192, NB=3).
1. Reset, then bands 1000/2000/3000 with gain_tgt all 4 (unity) -> out_valid exactly 5 clocks after accept; dato_dac=14192; busy high for 4 cycles.
2. Ramp down: band0=16384, other bands 0, gain_tgt0=0, five samples -> dato_dac = 20480, 16384, 12288, 8192, 8192. Then gain_tgt0=7 -> next outputs 12288, 16384, ... and settles at 36864 after 7 samples.
3. Saturation: all bands 2^23 with gain_cur 7 after ramp-up -> dato_dac=16777215. All bands -2^23 -> dato_dac=-16777216.
4. in_valid pulsed 2 clocks after an accept -> second sample ignored; result matches the first sample; overrun=1 and stays 1 until rst.
5. rst pulsed low during ACC -> busy=0 and dato_dac=0 immediately; no out_valid; the next sample (bands 1000/0/0, targets 4) gives 9192, confirming unity gain was restored.
6. Back-to-back: in_valid asserted in each out_valid cycle for 10 samples -> all 10 accepted; overrun stays 0; outputs in input order.
